// File: rtl/uart_rx_ctrl.sv
// UART receive controller: line synchronizer, mid-bit baud strobe, frame-done detect, byte FIFO.
// Optional macro UART_RX_FERR_EN: drop frames whose stop sample is 0 and raise sticky ferr.
module uart_rx_ctrl #(
    parameter int CLK_DIV = 868,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       rxd,
    output logic                       rxd_s,
    input  logic                       br_en,
    input  logic [7:0]                 rx_dout,
    output logic                       br_stb,
    output logic                       m_valid,
    output logic [7:0]                 m_data,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       ovf,
    output logic                       ferr,
    input  logic                       clr
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    // Preload so the first strobe lands CLK_DIV/2 cycles into the start bit.
    localparam logic [CW-1:0] CNT_PRE  = CW'(CLK_DIV - 1 - CLK_DIV / 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic                       sync1_q, sync2_q;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [3:0]                 scnt_q, scnt_d;
    logic [DEPTH-1:0][7:0]      mem_q, mem_d;
    logic [AW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]              level_q, level_d;
    logic                       ovf_q, ovf_d;
    logic                       frame_done, push_req, pop, full, push_ok, ovf_set;

    assign rxd_s   = sync2_q;
    assign m_valid = (level_q != '0);
    assign m_data  = mem_q[rd_ptr_q];
    assign level   = level_q;
    assign ovf     = ovf_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        br_stb     = br_en && (cnt_q == CNT_LAST);
        cnt_d      = CNT_PRE;
        scnt_d     = '0;
        frame_done = 1'b0;
        if (br_en) begin
            cnt_d  = br_stb ? '0 : cnt_q + CW'(1);
            scnt_d = scnt_q;
            if (br_stb) begin
                if (scnt_q == 4'd9) begin
                    frame_done = 1'b1;
                    scnt_d     = '0;
                end else begin
                    scnt_d = scnt_q + 4'd1;
                end
            end
        end
    end

`ifdef UART_RX_FERR_EN
    logic ferr_q, ferr_d, ferr_set;
    assign ferr     = ferr_q;
    assign push_req = frame_done && sync2_q;
    assign ferr_set = frame_done && !sync2_q;
    assign ferr_d   = ferr_set || (ferr_q && !clr);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ferr_q <= 1'b0;
        else       ferr_q <= ferr_d;
    end
`else
    assign ferr     = 1'b0;
    assign push_req = frame_done;
`endif

    // A full FIFO still accepts a byte if the head leaves in the same cycle.
    always_comb begin
        pop      = m_valid && m_ready;
        full     = (level_q == LW'(DEPTH));
        push_ok  = push_req && (!full || pop);
        ovf_set  = push_req && full && !pop;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = rx_dout;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        level_d  = level_q + LW'(push_ok) - LW'(pop);
        ovf_d    = ovf_set || (ovf_q && !clr);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q    <= CNT_PRE;
            scnt_q   <= '0;
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            scnt_q   <= scnt_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end
endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the UART byte receiver. Synchronizes the raw serial line, generates the receiver's baud strobe aligned to mid-bit from the receiver's `br_en` request, detects frame completion, and buffers received bytes in a small FIFO with a valid/ready output handshake. It sits between the pad/UART top level and the downstream byte consumer, with the receiver instance alongside.

## Interface
- `CLK_DIV`, 868: clk cycles per bit; must be ≥ 4.
- `DEPTH`, 4: FIFO entries; power of 2, ≥ 2.
- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `rxd`  in  1  raw serial line; idle high.
- `rxd_s`  out  1  synchronized line, drives the receiver `rxd`.
- `br_en`  in  1  receiver's combinational baud-enable request.
- `rx_dout`  in  8  receiver's shift-register output.
- `br_stb`  out  1  one-cycle baud strobe to the receiver.
- `m_valid`  out  1  FIFO non-empty.
- `m_data`  out  8  FIFO head byte, show-ahead.
- `m_ready`  in  1  consumer accept.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `ovf`  out  1  sticky: byte dropped, FIFO full.
- `ferr`  out  1  sticky framing error.
- `clr`  in  1  clears `ovf` and `ferr`.

## Operation
- Sync: 2 flops, both reset to 1; `rxd_s` is stage 2.
- Baud counter `cnt`:
  - While `br_en`=0: `cnt` preloads `CLK_DIV-1-CLK_DIV/2`.
  - While `br_en`=1: `br_stb = (cnt==CLK_DIV-1)`. When `br_stb` is 1, `cnt` wraps to 0; otherwise `cnt` increments.
  - `br_stb` is never asserted while `br_en`=0.
- Strobe counter `scnt`, range 0..9:
  - Cleared while `br_en`=0.
  - Increments on each `br_stb`.
  - The strobe with `scnt==9` (the 10th strobe, mid stop bit) is the frame-done event. `scnt` returns to 0 on this event.
- Frame done:
  - Sample `rxd_s` as the stop bit.
  - Push `rx_dout`. `rx_dout` is already final, having been shifted on strobe 9.
  - Push qualification follows the Configuration section.
- FIFO:
  - Pop when `m_valid && m_ready`. `m_valid = (level != 0)`.
  - `m_data` shows the head entry. Storage resets to 0.
  - Push while full is accepted only if a pop occurs in the same cycle. `level` is then unchanged.
  - Push while full without a pop drops the byte and sets `ovf`.
  - Pointers wrap modulo `DEPTH`.
- Flags: `clr` clears `ovf` and `ferr`. If a set event occurs in the same cycle as `clr`, the set wins.
- Reset values:
  - `rxd_s`=1.
  - `br_stb`=0, `m_valid`=0, `m_data`=0, `level`=0, `ovf`=0, `ferr`=0.
  - `cnt`=preload, `scnt`=0.
  - Reset mid-frame abandons the frame with no push. The receiver shares `rstn`.

## Timing
- `rxd` to `rxd_s`: 2 cycles.
- First `br_stb` occurs `CLK_DIV/2` cycles after the first cycle with `br_en`=1. Subsequent strobes occur every `CLK_DIV` cycles.
- Ten strobes per frame: start, 8 data bits, stop.
- `m_valid` and `level` update 1 cycle after the frame-done strobe.
- Pop updates `m_data` and `level` in the next cycle.
- Back-to-back frames are supported: a new start bit 1 stop bit after frame done is received without loss.

## Configuration
- `UART_RX_FERR_EN` defined:
  - A stop sample of 0 drops the byte (no push) and sets `ferr`.
  - A stop sample of 1 pushes the byte.
- Undefined:
  - Every frame is pushed regardless of the stop sample.
  - `ferr` is tied to 0.
  - `clr` affects only `ovf`.

## Test plan
- All scenarios use `CLK_DIV`=16 and `DEPTH`=4.
- Send 0xA5 with stop=1:
  - First `br_stb` 8 cycles after `br_en` rises, then every 16 cycles; 10 strobes in total.
  - 1 cycle after the 10th strobe: `m_valid`=1, `m_data`=0xA5, `level`=1, `ferr`=0.
- Send 0x01..0x05 with `m_ready`=0:
  - `level`=4 and `ovf`=1 after the 5th frame.
  - Pops then return 0x01, 0x02, 0x03, 0x04; 0x05 is lost.
- FIFO full, with `m_ready`=1 held on the frame-done cycle of 0x77 → 0x77 stored, `level` stays 4, `ovf`=0.
- Send 0x3C with stop=0:
  - With `UART_RX_FERR_EN`: no push, `ferr`=1. Pulse `clr` → `ferr`=0.
  - Without `UART_RX_FERR_EN`: 0x3C pushed, `ferr`=0.
- Assert `rstn` after 4 strobes of a frame:
  - All outputs return to reset values.
  - A following 0x5A frame is received correctly.
- Send 0xFF then 0x00 back-to-back with 1 stop bit → both bytes pushed in order, `ovf`=0.
